// File: rtl/distance_smoother.sv
// distance_smoother: range-gates raw ultrasonic distance samples and produces a
// moving average over the last 2^LOG2_DEPTH accepted samples. It also tracks a
// staleness timer so that downstream display/tone logic can tell old data from live data.

// One ring-buffer slot; written either alone (steady state) or together with
// every other slot (priming).
module distance_smoother_entry #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              we_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] q_q;

  // slot storage, cleared on reset so that history is discarded
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)   q_q <= '0;
    else if (we_i) q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

module distance_smoother #(
  parameter int DATA_W       = 8,
  parameter int LOG2_DEPTH   = 3,
  parameter int MAX_VALID    = 200,
  parameter int STALE_CYCLES = 50000000,
  parameter int STALE_W      = 26
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid,
  output logic              primed,
  output logic              stale,
  output logic [7:0]        reject_count
);

  localparam int                DEPTH     = 1 << LOG2_DEPTH;
  localparam int                SUM_W     = DATA_W + LOG2_DEPTH;
  localparam logic [DATA_W-1:0] MAX_LIM   = DATA_W'(MAX_VALID);
  localparam logic [STALE_W-1:0] STALE_LIM = STALE_W'(STALE_CYCLES);

  // ring buffer slots
  logic [DEPTH-1:0][DATA_W-1:0] ring_q;
  logic [DEPTH-1:0]             ent_we;

  // control / datapath state
  logic [SUM_W-1:0]      sum_q,    sum_d;
  logic [LOG2_DEPTH-1:0] wptr_q,   wptr_d;
  logic [STALE_W-1:0]    timer_q,  timer_d;
  logic [7:0]            rej_q,    rej_d;
  logic                  primed_q;
  logic                  upd_q;
  logic [DATA_W-1:0]     avg_q;
  logic                  avg_vld_q;

  logic              accept, reject, prime, steady, stale_now;
  logic [DATA_W-1:0] oldest;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ent
      distance_smoother_entry #(.DATA_W(DATA_W)) u_ent (
        .clock  (clock),
        .resetn (resetn),
        .we_i   (ent_we[g]),
        .d_i    (sample_in),
        .q_o    (ring_q[g])
      );
    end
  endgenerate

  // stale is a pure function of the saturated timer register
  assign stale_now = (timer_q == STALE_LIM);

  // accept/reject classification and the priming vs steady-state split;
  // a stale buffer is refilled rather than averaged with old data
  always_comb begin
    accept = sample_valid && (sample_in != '0) && (sample_in <= MAX_LIM);
    reject = sample_valid && !accept;
    prime  = accept && (!primed_q || stale_now);
    steady = accept && !prime;
    oldest = ring_q[wptr_q];
    for (int i = 0; i < DEPTH; i++)
      ent_we[i] = prime || (steady && (wptr_q == LOG2_DEPTH'(i)));
  end

  // running sum and write pointer next state; the sum is wide enough to hold
  // DEPTH full-scale samples, so the subtract-then-add can never wrap
  always_comb begin
    sum_d  = sum_q;
    wptr_d = wptr_q;
    if (prime) begin
      sum_d  = {sample_in, {LOG2_DEPTH{1'b0}}};
      wptr_d = LOG2_DEPTH'(1);
    end else if (steady) begin
      sum_d  = sum_q - SUM_W'(oldest) + SUM_W'(sample_in);
      wptr_d = wptr_q + LOG2_DEPTH'(1);
    end
  end

  // stale timer and saturating reject counter next state
  always_comb begin
    timer_d = timer_q;
    rej_d   = rej_q;
    if (accept)               timer_d = '0;
    else if (!stale_now)      timer_d = timer_q + STALE_W'(1);
    if (reject && rej_q != 8'hFF) rej_d = rej_q + 8'd1;
  end

  // buffer bookkeeping registers, updated on the accepting edge
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sum_q    <= '0;
      wptr_q   <= '0;
      primed_q <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      sum_q    <= sum_d;
      wptr_q   <= wptr_d;
      upd_q    <= accept;
      if (accept) primed_q <= 1'b1;
    end
  end

  // timer and reject counter registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      timer_q <= '0;
      rej_q   <= '0;
    end else begin
      timer_q <= timer_d;
      rej_q   <= rej_d;
    end
  end

  // output stage: one edge after the sum settles, publish the truncated mean
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      avg_q     <= '0;
      avg_vld_q <= 1'b0;
    end else begin
      avg_vld_q <= upd_q;
      if (upd_q) avg_q <= sum_q[SUM_W-1:LOG2_DEPTH];
    end
  end

  assign avg_out      = avg_q;
  assign avg_valid    = avg_vld_q;
  assign primed       = primed_q;
  assign stale        = stale_now;
  assign reject_count = rej_q;

endmodule

// File: tb/tb_distance_smoother.sv
// Bench for distance_smoother: directed scenarios plus random traffic, checked
// against a window/queue reference model.
module tb_distance_smoother;

  localparam int STALE = 100;
  localparam int MAXV  = 200;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] sample_in = '0;
  logic       sample_valid = 1'b0;
  logic [7:0] avg_out;
  logic       avg_valid;
  logic       primed;
  logic       stale;
  logic [7:0] reject_count;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int win[$];
  bit m_primed;
  int m_idle;
  int m_rej;
  bit m_pend;
  int m_pend_val;
  bit m_avg_valid;
  int m_avg;

  distance_smoother #(
    .DATA_W(8), .LOG2_DEPTH(3), .MAX_VALID(MAXV),
    .STALE_CYCLES(STALE), .STALE_W(7)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .avg_out      (avg_out),
    .avg_valid    (avg_valid),
    .primed       (primed),
    .stale        (stale),
    .reject_count (reject_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    win.delete();
    m_primed = 0; m_idle = 0; m_rej = 0;
    m_pend = 0; m_pend_val = 0; m_avg_valid = 0; m_avg = 0;
  endtask

  // one rising edge worth of the reference behaviour
  task automatic model_step(input bit v, input int d);
    bit stale_before;
    bit acc;
    int s;
    stale_before = (m_idle == STALE);
    m_avg_valid  = m_pend;
    if (m_pend) m_avg = m_pend_val;
    m_pend = 0;
    acc = v && (d >= 1) && (d <= MAXV);
    if (v && !acc && m_rej < 255) m_rej++;
    if (acc) begin
      if (!m_primed || stale_before) begin
        win.delete();
        repeat (8) win.push_back(d);
      end else begin
        void'(win.pop_front());
        win.push_back(d);
      end
      m_primed = 1;
      m_idle   = 0;
      s = 0;
      foreach (win[i]) s += win[i];
      m_pend     = 1;
      m_pend_val = s / 8;
    end else if (m_idle < STALE) begin
      m_idle++;
    end
  endtask

  task automatic check_outs();
    chk("avg_valid", avg_valid, m_avg_valid);
    chk("avg_out", avg_out, m_avg);
    chk("primed", primed, m_primed);
    chk("stale", stale, (m_idle == STALE));
    chk("reject_count", reject_count, m_rej);
  endtask

  // drive one cycle (entered just after a falling edge), check at the next falling edge
  task automatic cyc(input bit v, input int d);
    sample_valid = v;
    sample_in    = d[7:0];
    @(posedge clock);
    model_step(v, d);
    @(negedge clock);
    sample_valid = 1'b0;
    sample_in    = '0;
    check_outs();
  endtask

  // asynchronous reset pulse between edges; outputs must clear before any edge
  task automatic do_reset();
    #2 resetn = 1'b0;
    #1;
    chk("rst_avg_out", avg_out, 0);
    chk("rst_avg_valid", avg_valid, 0);
    chk("rst_primed", primed, 0);
    chk("rst_stale", stale, 0);
    chk("rst_reject", reject_count, 0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    check_outs();
  endtask

  initial begin
    int exp8[9] = '{45, 50, 55, 60, 65, 70, 75, 80, 80};
    int cnt;
    int r, d;
    bit v;

    model_reset();
    repeat (2) @(negedge clock);
    chk("init_avg_out", avg_out, 0);
    chk("init_primed", primed, 0);
    chk("init_stale", stale, 0);
    chk("init_reject", reject_count, 0);
    resetn = 1'b1;

    // first sample primes the window
    cyc(1, 40);
    chk("t1_no_early_valid", avg_valid, 0);
    cyc(0, 0);
    chk("t1_valid", avg_valid, 1);
    chk("t1_avg", avg_out, 40);
    chk("t1_primed", primed, 1);

    // back-to-back 80s ramp the mean, ninth confirms wrap
    for (int k = 0; k < 9; k++) begin
      cyc(1, 80);
      if (k > 0) chk("t2_seq", avg_out, exp8[k-1]);
    end
    cyc(0, 0);
    chk("t2_wrap", avg_out, 80);

    // rejects leave the average untouched
    do_reset();
    cyc(1, 40);
    cyc(0, 0);
    cyc(1, 0);
    cyc(1, 250);
    cyc(0, 0);
    chk("t3_no_valid", avg_valid, 0);
    chk("t3_hold", avg_out, 40);
    chk("t3_rej", reject_count, 2);
    cyc(1, 200);
    cyc(0, 0);
    chk("t3_avg200", avg_out, 60);

    // stale rises exactly STALE cycles after the accept, then re-primes
    do_reset();
    cyc(1, 40);
    cnt = 0;
    while (!stale && cnt < 200) begin
      cyc(0, 0);
      cnt++;
    end
    chk("t4_stale_latency", cnt, STALE);
    cyc(1, 30);
    cyc(0, 0);
    chk("t4_reprime", avg_out, 30);
    chk("t4_stale_clr", stale, 0);

    // sample on the edge the timer would saturate: steady-state, not re-prime
    do_reset();
    cyc(1, 40);
    repeat (STALE - 1) cyc(0, 0);
    chk("t4b_not_stale", stale, 0);
    cyc(1, 80);
    cyc(0, 0);
    chk("t4b_steady", avg_out, 45);
    chk("t4b_stale", stale, 0);

    // reset in the middle of a stream discards history
    do_reset();
    cyc(1, 40);
    repeat (3) cyc(1, 80);
    do_reset();
    cyc(1, 10);
    cyc(0, 0);
    chk("t5_after_rst", avg_out, 10);

    // reject counter saturation
    do_reset();
    repeat (300) cyc(1, 255);
    chk("t6_rej_sat", reject_count, 255);
    chk("t6_unprimed", primed, 0);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) repeat (STALE + 20) cyc(0, 0);
      if (i == 300) do_reset();
      r = $urandom_range(0, 9);
      v = (r < 6);
      r = $urandom_range(0, 9);
      if (r == 0)      d = 0;
      else if (r == 1) d = $urandom_range(201, 255);
      else             d = $urandom_range(1, 200);
      cyc(v, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
